// File: rtl/dram_timing_ctrl_if.sv
// Command-state type shared with the command FSM, and the bundle of signals
// exchanged between the FSM and its timing responder.
package dram_timing_pkg;
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ACTIVATE,
        READ,
        WRITE,
        PRECHARGE,
        REFRESH,
        NOP
    } dram_state_t;
endpackage

interface dram_timing_ctrl_if;
    import dram_timing_pkg::*;

    dram_state_t cmd_state;
    dram_state_t ncmd_state;
    logic        init_done;
    logic        tACT_done;
    logic        tRD_done;
    logic        tWR_done;
    logic        tPRE_done;
    logic        tREF_done;
    logic        rf_req;

    modport master (
        output cmd_state, ncmd_state, init_done,
        input  tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req
    );

    modport slave (
        input  cmd_state, ncmd_state, init_done,
        output tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req
    );
endinterface

// File: rtl/dram_timing_ctrl.sv
// Timing responder for the DRAM command FSM: times each command state and
// raises its done in the last cycle, and queues periodic refresh requests.
module dram_timing_ctrl
    import dram_timing_pkg::*;
#(
    parameter int T_RCD    = 4,
    parameter int T_RD     = 8,
    parameter int T_WR     = 10,
    parameter int T_RP     = 4,
    parameter int T_RFC    = 32,
    parameter int T_REFI   = 1560,
    parameter int CNT_W    = 16,
    parameter int PEND_MAX = 7
) (
    input  logic              CLK,
    input  logic              nRST,
    dram_timing_ctrl_if.slave bus
);
    localparam int REFI_W = $clog2(T_REFI);
    localparam int PEND_W = $clog2(PEND_MAX + 1);
    localparam logic [REFI_W-1:0] REFI_LD  = REFI_W'(T_REFI - 1);
    localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

    function automatic logic [CNT_W-1:0] load_value(input dram_state_t s);
        logic [CNT_W-1:0] ld;
        ld = '0;
        case (s)
            ACTIVATE:  ld = CNT_W'(T_RCD - 1);
            READ:      ld = CNT_W'(T_RD - 1);
            WRITE:     ld = CNT_W'(T_WR - 1);
            PRECHARGE: ld = CNT_W'(T_RP - 1);
            REFRESH:   ld = CNT_W'(T_RFC - 1);
            default:   ld = '0;
        endcase
        return ld;
    endfunction

    logic [CNT_W-1:0]  cnt;
    logic [REFI_W-1:0] ref_cnt;
    logic [PEND_W-1:0] pend;
    logic              armed;
    logic              state_change;
    logic              timed;
    logic              done;
    logic              ref_expire;
    logic              ref_entry;

    // armed keeps a reset taken mid-command from completing that command on release.
    always_comb begin
        state_change = (bus.ncmd_state != bus.cmd_state);
        timed        = (bus.cmd_state == ACTIVATE) || (bus.cmd_state == READ) ||
                       (bus.cmd_state == WRITE) || (bus.cmd_state == PRECHARGE) ||
                       (bus.cmd_state == REFRESH);
        done         = timed && (cnt == '0) && bus.init_done && armed;
        ref_expire   = bus.init_done && (ref_cnt == '0);
        ref_entry    = (bus.ncmd_state == REFRESH) && (bus.cmd_state != REFRESH);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            if (state_change) begin
                cnt   <= load_value(bus.ncmd_state);
                armed <= 1'b1;
            end else if (done) begin
                cnt <= load_value(bus.cmd_state);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ref_cnt <= REFI_LD;
        end else if (!bus.init_done || (ref_cnt == '0)) begin
            ref_cnt <= REFI_LD;
        end else begin
            ref_cnt <= ref_cnt - REFI_W'(1);
        end
    end

    // An expiry and a refresh entry on the same edge cancel out.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend <= '0;
        end else if (ref_expire && !ref_entry) begin
            if (pend != PEND_TOP) pend <= pend + PEND_W'(1);
        end else if (ref_entry && !ref_expire) begin
            if (pend != '0) pend <= pend - PEND_W'(1);
        end
    end

    assign bus.tACT_done = done && (bus.cmd_state == ACTIVATE);
    assign bus.tRD_done  = done && (bus.cmd_state == READ);
    assign bus.tWR_done  = done && (bus.cmd_state == WRITE);
    assign bus.tPRE_done = done && (bus.cmd_state == PRECHARGE);
    assign bus.tREF_done = done && (bus.cmd_state == REFRESH);
    assign bus.rf_req    = (pend != '0);

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Directed bench for dram_timing_ctrl; the bench plays the command FSM and
// checks done pulses and refresh requests against hand-computed cycles.
module tb_dram_timing_ctrl;
    import dram_timing_pkg::*;

    localparam int TREFI = 1560;

    localparam logic [4:0] D_NONE = 5'b00000;
    localparam logic [4:0] D_ACT  = 5'b10000;
    localparam logic [4:0] D_RD   = 5'b01000;
    localparam logic [4:0] D_WR   = 5'b00100;
    localparam logic [4:0] D_PRE  = 5'b00010;
    localparam logic [4:0] D_REF  = 5'b00001;

    logic CLK;
    logic nRST;
    int   testsRun;
    int   testsFailed;

    dram_timing_ctrl_if bus ();

    dram_timing_ctrl dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Minimal command FSM: the current state follows the driven next state.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) bus.cmd_state <= IDLE;
        else       bus.cmd_state <= bus.ncmd_state;
    end

    function automatic logic [4:0] doneVec();
        return {bus.tACT_done, bus.tRD_done, bus.tWR_done, bus.tPRE_done, bus.tREF_done};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs n edges from a freshly reloaded refresh counter and checks rf_req
    // is still low after n-1 edges and high after n.
    task automatic applyStimulus(input string tag, input int n);
        for (int j = 1; j <= n; j++) begin
            tick();
            if (j == n - 1) checkOutput({tag, "_before"}, 32'(bus.rf_req), 32'd0);
            if (j == n)     checkOutput({tag, "_at"}, 32'(bus.rf_req), 32'd1);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        nRST           = 1'b0;
        bus.init_done  = 1'b0;
        bus.ncmd_state = IDLE;
        #3;
        checkOutput("reset_done", 32'(doneVec()), 32'(D_NONE));
        checkOutput("reset_rf_req", 32'(bus.rf_req), 32'd0);
        @(posedge CLK);
        #2 nRST = 1'b1;
        tick();
        bus.init_done = 1'b1;
        tick();

        // Single ACTIVATE
        bus.ncmd_state = ACTIVATE;
        tick();
        for (int c = 0; c <= 3; c++) begin
            checkOutput($sformatf("act_c%0d", c), 32'(doneVec()), 32'((c == 3) ? D_ACT : D_NONE));
            if (c == 3) bus.ncmd_state = IDLE;
            tick();
        end
        checkOutput("act_idle", 32'(doneVec()), 32'(D_NONE));

        // Back-to-back READs
        bus.ncmd_state = READ;
        tick();
        for (int c = 0; c <= 15; c++) begin
            checkOutput($sformatf("rd_c%0d", c), 32'(doneVec()),
                        32'(((c == 7) || (c == 15)) ? D_RD : D_NONE));
            if (c == 15) bus.ncmd_state = IDLE;
            tick();
        end

        // WRITE aborted early into PRECHARGE
        bus.ncmd_state = WRITE;
        tick();
        for (int c = 0; c <= 2; c++) begin
            checkOutput($sformatf("wr_c%0d", c), 32'(doneVec()), 32'(D_NONE));
            if (c == 2) bus.ncmd_state = PRECHARGE;
            tick();
        end
        for (int c = 0; c <= 3; c++) begin
            checkOutput($sformatf("pre_c%0d", c), 32'(doneVec()), 32'((c == 3) ? D_PRE : D_NONE));
            if (c == 3) bus.ncmd_state = IDLE;
            tick();
        end
        checkOutput("pre_idle", 32'(doneVec()), 32'(D_NONE));

        // First refresh request, then service it
        bus.init_done = 1'b0;
        tick();
        tick();
        checkOutput("noinit_rf_req", 32'(bus.rf_req), 32'd0);
        bus.init_done = 1'b1;
        applyStimulus("refi", TREFI);
        bus.ncmd_state = REFRESH;
        tick();
        checkOutput("ref_entry_rf_req", 32'(bus.rf_req), 32'd0);
        for (int c = 0; c <= 31; c++) begin
            if (c == 0 || c == 30 || c == 31)
                checkOutput($sformatf("ref_c%0d", c), 32'(doneVec()), 32'((c == 31) ? D_REF : D_NONE));
            if (c == 31) bus.ncmd_state = IDLE;
            tick();
        end
        checkOutput("ref_idle", 32'(doneVec()), 32'(D_NONE));

        // Nine intervals withheld: the queue saturates at seven
        bus.init_done = 1'b0;
        tick();
        bus.init_done = 1'b1;
        for (int j = 0; j < 9 * TREFI; j++) tick();
        checkOutput("sat_rf_req", 32'(bus.rf_req), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            bus.ncmd_state = REFRESH;
            tick();
            bus.ncmd_state = IDLE;
            tick();
            checkOutput($sformatf("sat_serv%0d", k), 32'(bus.rf_req), 32'((k < 7) ? 1 : 0));
        end
        checkOutput("sat_idle_done", 32'(doneVec()), 32'(D_NONE));

        // Reset mid-REFRESH with refreshes still owed
        bus.init_done = 1'b0;
        tick();
        bus.init_done = 1'b1;
        for (int j = 0; j < 2 * TREFI; j++) tick();
        bus.ncmd_state = REFRESH;
        tick();
        checkOutput("mid_ref_rf_req", 32'(bus.rf_req), 32'd1);
        tick();
        tick();
        #3 nRST = 1'b0;
        bus.ncmd_state = IDLE;
        #1;
        checkOutput("async_rst_done", 32'(doneVec()), 32'(D_NONE));
        checkOutput("async_rst_rf_req", 32'(bus.rf_req), 32'd0);
        tick();
        #2 nRST = 1'b1;
        tick();
        checkOutput("post_rst_done", 32'(doneVec()), 32'(D_NONE));
        for (int j = 2; j <= TREFI; j++) begin
            tick();
            if (j == TREFI - 1) checkOutput("post_rst_refi_before", 32'(bus.rf_req), 32'd0);
            if (j == TREFI)     checkOutput("post_rst_refi_at", 32'(bus.rf_req), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
